// File: rtl/wide_add_sequencer_if.sv
// rtl/wide_add_sequencer_if.sv - operand request, adder slice and result bundle for wide_add_sequencer
interface wide_add_sequencer_if #(
    parameter int NWORDS = 4
);
    logic                   in_valid;
    logic                   in_ready;
    logic [16*NWORDS-1:0]   op_a;
    logic [16*NWORDS-1:0]   op_b;
    logic                   op_cin;
    logic                   op_sub;

    logic [15:0]            adder_a;
    logic [15:0]            adder_b;
    logic                   adder_cin;
    logic [15:0]            adder_sum;
    logic                   adder_cout;

    logic                   out_valid;
    logic                   out_ready;
    logic [16*NWORDS-1:0]   result;
    logic                   carry_out;
    logic                   overflow;

    modport master (
        output in_valid, op_a, op_b, op_cin, op_sub,
        output adder_sum, adder_cout,
        output out_ready,
        input  in_ready,
        input  adder_a, adder_b, adder_cin,
        input  out_valid, result, carry_out, overflow
    );

    modport slave (
        input  in_valid, op_a, op_b, op_cin, op_sub,
        input  adder_sum, adder_cout,
        input  out_ready,
        output in_ready,
        output adder_a, adder_b, adder_cin,
        output out_valid, result, carry_out, overflow
    );
endinterface

// File: rtl/wide_add_sequencer.sv
// rtl/wide_add_sequencer.sv - slices a wide add/subtract through an external 16-bit adder
module wide_add_sequencer #(
    parameter int NWORDS = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    wide_add_sequencer_if.slave  bus
);
    localparam int W     = 16 * NWORDS;
    localparam int IDX_W = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NWORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic [IDX_W-1:0]   idx;
    logic [IDX_W+3:0]   slice_lsb;
    logic [W-1:0]       a_reg;
    logic [W-1:0]       b_reg;
    logic [W-1:0]       result_reg;
    logic               carry;
    logic               carry_out_reg;
    logic               overflow_reg;
    logic               last_slice;

    // Bit offset of the slice currently on the adder
    assign slice_lsb  = {idx, 4'b0000};
    assign last_slice = (idx == LAST_IDX);

    assign bus.result    = result_reg;
    assign bus.carry_out = carry_out_reg;
    assign bus.overflow  = overflow_reg;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state, handshakes and adder slice drive; adder inputs stay zero outside RUN
    always_comb begin
        state_nxt     = state;
        bus.in_ready  = 1'b0;
        bus.out_valid = 1'b0;
        bus.adder_a   = 16'h0000;
        bus.adder_b   = 16'h0000;
        bus.adder_cin = 1'b0;
        case (state)
            S_IDLE: begin
                bus.in_ready = !rst;
                if (bus.in_valid && !rst) begin
                    state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                bus.adder_a   = a_reg[slice_lsb +: 16];
                bus.adder_b   = b_reg[slice_lsb +: 16];
                bus.adder_cin = carry;
                if (last_slice) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready) begin
                    state_nxt = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Operand capture, slice-by-slice result assembly and final flags
    always_ff @(posedge clk) begin
        if (rst) begin
            idx           <= '0;
            carry         <= 1'b0;
            a_reg         <= '0;
            b_reg         <= '0;
            result_reg    <= '0;
            carry_out_reg <= 1'b0;
            overflow_reg  <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        a_reg <= bus.op_a;
                        b_reg <= bus.op_sub ? ~bus.op_b : bus.op_b;
                        carry <= bus.op_sub ? 1'b1 : bus.op_cin;
                        idx   <= '0;
                    end
                end
                S_RUN: begin
                    result_reg[slice_lsb +: 16] <= bus.adder_sum;
                    carry                       <= bus.adder_cout;
                    if (last_slice) begin
                        idx           <= '0;
                        carry_out_reg <= bus.adder_cout;
                        overflow_reg  <= (a_reg[W-1] == b_reg[W-1]) &&
                                         (bus.adder_sum[15] != a_reg[W-1]);
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end
endmodule

// File: tb/tb_wide_add_sequencer.sv
// tb/tb_wide_add_sequencer.sv - self-checking bench for wide_add_sequencer
module tb_wide_add_sequencer;
    localparam int NW = 4;
    localparam int W  = 16 * NW;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    wide_add_sequencer_if #(.NWORDS(NW)) bus();

    wide_add_sequencer #(.NWORDS(NW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Stand-in for the combinational Prefix_Adder
    assign {bus.adder_cout, bus.adder_sum} = 17'(bus.adder_a) + 17'(bus.adder_b) + 17'(bus.adder_cin);

    int total = 0;
    int bad   = 0;

    logic [W-1:0]  cap_a;
    logic [NW-1:0] cap_cin;
    logic          lat_ok;
    logic          issued;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         cin;
        logic         sub;
        logic [W-1:0] r;
        logic         c;
        logic         v;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Reference: whole-word arithmetic, signed overflow from an extended signed sum
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic cin, input logic sub,
                                  output logic [W-1:0] r, output logic c, output logic v);
        logic [W:0]          u;
        logic signed [W+1:0] s;
        logic signed [W+1:0] sa;
        logic signed [W+1:0] sb;
        sa = $signed({{2{a[W-1]}}, a});
        sb = $signed({{2{b[W-1]}}, b});
        if (sub) begin
            r = a - b;
            c = (a >= b);
            s = sa - sb;
        end else begin
            u = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
            r = u[W-1:0];
            c = u[W];
            s = sa + sb + $signed({(W+1)'(0), cin});
        end
        v = (s != $signed({{2{r[W-1]}}, r}));
    endfunction

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub);
        int n;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.op_sub   = sub;
        n = 0;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        issued = bus.in_ready;
        chk1("accept_ready", bus.in_ready, 1'b1);
        if (!issued) begin
            bus.in_valid = 1'b0;
            return;
        end
        @(posedge clk);
        lat_ok = 1'b1;
        for (int k = 0; k < NW; k++) begin
            @(negedge clk);
            bus.in_valid = 1'b0;
            cap_a[16*k +: 16] = bus.adder_a;
            cap_cin[k]        = bus.adder_cin;
            if (bus.out_valid) lat_ok = 1'b0;
        end
        @(negedge clk);
        if (!bus.out_valid) lat_ok = 1'b0;
    endtask

    task automatic retire();
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk1("retire_out_valid", bus.out_valid, 1'b0);
        chk1("retire_in_ready", bus.in_ready, 1'b1);
    endtask

    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin, input logic sub,
                          input int hold, input logic [W-1:0] er, input logic ec, input logic ev);
        logic [W-1:0] r0;
        logic         stable;
        issue(a, b, cin, sub);
        if (!issued) return;
        chk1("latency", lat_ok, 1'b1);
        check("result", bus.result, er);
        chk1("carry_out", bus.carry_out, ec);
        chk1("overflow", bus.overflow, ev);
        r0 = bus.result;
        stable = 1'b1;
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            if (!bus.out_valid || bus.result !== r0 || bus.in_ready) stable = 1'b0;
        end
        if (hold > 0) chk1("hold_stable", stable, 1'b1);
        retire();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [W-1:0] pa, pb, qa, qb, er;
        logic         pc, ps, qc, qs, ec, ev;
        logic         seen_valid;
        int           n;

        vecs[0] = '{64'h0000_0000_0000_0003, 64'h2, 1'b0, 1'b0, 64'h5, 1'b0, 1'b0};
        vecs[1] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0};
        vecs[2] = '{64'h0000_0000_0001_0000, 64'h1, 1'b0, 1'b1, 64'h0000_0000_0000_FFFF, 1'b1, 1'b0};
        vecs[3] = '{64'h0, 64'h1, 1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};
        vecs[4] = '{64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b0, 64'h8000_0000_0000_0000, 1'b0, 1'b1};
        vecs[5] = '{64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 1'b1, 1'b0, 64'h1, 1'b1, 1'b1};
        vecs[6] = '{64'hAAAA_AAAA_AAAA_AAAA, 64'h5555_5555_5555_5555, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0};

        bus.in_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.op_sub    = 1'b0;
        bus.out_ready = 1'b0;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk1("in_ready_during_rst", bus.in_ready, 1'b0);
        rst = 1'b0;
        #1;
        chk1("rst_in_ready", bus.in_ready, 1'b1);
        chk1("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_result", bus.result, '0);
        chk1("rst_carry_out", bus.carry_out, 1'b0);
        chk1("rst_overflow", bus.overflow, 1'b0);
        check("rst_adder_a", W'(bus.adder_a), '0);

        for (int i = 0; i < 6; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, i % 3, vecs[i].r, vecs[i].c, vecs[i].v);
            if (i == 0) begin
                check("t1_adder_a_seq", cap_a, 64'h0000_0000_0000_0003);
                check("t1_adder_cin_seq", W'(cap_cin), W'(4'b0000));
            end
            if (i == 1) begin
                check("t2_adder_cin_seq", W'(cap_cin), W'(4'b1111));
            end
        end

        pa = 64'h1234_5678_9ABC_DEF0; pb = 64'h0FED_CBA9_8765_4321; pc = 1'b1; ps = 1'b0;
        model(pa, pb, pc, ps, er, ec, ev);
        issue(pa, pb, pc, ps);
        check("bp_result", bus.result, er);
        for (int k = 0; k < 5; k++) begin
            bus.in_valid = (k % 2 == 0);
            bus.op_a     = {$urandom, $urandom};
            bus.op_b     = {$urandom, $urandom};
            bus.out_ready = 1'b0;
            @(negedge clk);
            chk1("bp_out_valid_held", bus.out_valid, 1'b1);
            chk1("bp_in_ready_low", bus.in_ready, 1'b0);
            check("bp_result_held", bus.result, er);
            chk1("bp_carry_held", bus.carry_out, ec);
            chk1("bp_ovf_held", bus.overflow, ev);
        end
        qa = 64'hFFFF_0000_FFFF_0000; qb = 64'h0001_0001_0001_0001; qc = 1'b0; qs = 1'b1;
        bus.in_valid  = 1'b1;
        bus.op_a      = qa;
        bus.op_b      = qb;
        bus.op_cin    = qc;
        bus.op_sub    = qs;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        chk1("bp_idle_out_valid", bus.out_valid, 1'b0);
        chk1("bp_idle_in_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        chk1("bp_queued_accepted", bus.in_ready, 1'b0);
        n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("bp_queued_latency", W'(n), W'(NW));
        model(qa, qb, qc, qs, er, ec, ev);
        check("bp_queued_result", bus.result, er);
        chk1("bp_queued_carry", bus.carry_out, ec);
        chk1("bp_queued_ovf", bus.overflow, ev);
        retire();

        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.op_a     = 64'h1111_1111_1111_1111;
        bus.op_b     = 64'h1111_1111_1111_1111;
        bus.op_cin   = 1'b0;
        bus.op_sub   = 1'b0;
        chk1("abort_accept_ready", bus.in_ready, 1'b1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk1("abort_in_ready", bus.in_ready, 1'b1);
        chk1("abort_out_valid", bus.out_valid, 1'b0);
        check("abort_result", bus.result, '0);
        seen_valid = 1'b0;
        for (int k = 0; k < NW + 2; k++) begin
            @(negedge clk);
            if (bus.out_valid) seen_valid = 1'b1;
        end
        chk1("abort_no_out_valid", seen_valid, 1'b0);
        run_op(vecs[6].a, vecs[6].b, vecs[6].cin, vecs[6].sub, 0, vecs[6].r, vecs[6].c, vecs[6].v);

        for (int i = 0; i < 30; i++) begin
            pa = {$urandom, $urandom};
            pb = {$urandom, $urandom};
            if (i % 5 == 0) pb = pa;
            pc = 1'($urandom_range(0, 1));
            ps = 1'($urandom_range(0, 1));
            model(pa, pb, pc, ps, er, ec, ev);
            run_op(pa, pb, pc, ps, $urandom_range(0, 3), er, ec, ev);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
